// File: rtl/hazard_forward_unit_if.sv
// ID-stage hazard/forwarding bus: decoded ID metadata in, stall and EX operand selects out.
// The debug signals expose the RUN/STALL view and the shadow pipeline contents.
interface hazard_forward_unit_if;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_uses_rs1;
    logic        id_uses_rs2;
    logic [4:0]  id_rd;
    logic        id_reg_write;
    logic        id_mem_read;
    logic        flush;
    logic        stall;
    logic [1:0]  forward_a;
    logic [1:0]  forward_b;
    logic [15:0] stall_count;
    logic        fsm_state;   // 0 = RUN, 1 = STALL
    logic [23:0] shadow_dbg;  // {ex, mem, wb}, each {valid, rd[4:0], reg_write, mem_read}

    // Handshake: no valid/ready pair. id_valid qualifies the ID fields every cycle;
    // stall is the back-pressure and must hold PC and IF/ID in the same cycle.
    modport master (
        output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        output id_rd, id_reg_write, id_mem_read, flush,
        input  stall, forward_a, forward_b, stall_count, fsm_state, shadow_dbg
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        input  id_rd, id_reg_write, id_mem_read, flush,
        output stall, forward_a, forward_b, stall_count, fsm_state, shadow_dbg
    );
endinterface

// File: rtl/hazard_forward_unit.sv
// Load-use stall and EX operand-forwarding select generator for the 5-stage pipeline.
// Optional stall statistics counter enabled by defining HAZARD_STATS_EN.
module hazard_forward_unit (
    input logic                  clk,
    input logic                  reset,
    hazard_forward_unit_if.slave bus
);
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_read;
    } shadow_t;

    typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_e;

    shadow_t    ex_q, ex_d, mem_q, wb_q;
    logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic       hazard, bubble;
    state_e     state_q, state_d;

    function automatic logic produces(input shadow_t s, input logic [4:0] r);
        return s.valid && s.reg_write && (s.rd == r) && (r != 5'd0);
    endfunction

    // Nearest producer wins; WB is never forwarded since the register file writes before reading.
    function automatic logic [1:0] fwd_sel(input logic uses, input logic [4:0] r,
                                           input shadow_t ex_s, input shadow_t mem_s);
        if (!uses)                 return 2'b00;
        else if (produces(ex_s, r))  return 2'b10;
        else if (produces(mem_s, r)) return 2'b01;
        else                       return 2'b00;
    endfunction

    always_comb begin
        hazard = bus.id_valid && !bus.flush && ex_q.valid && ex_q.mem_read &&
                 (ex_q.rd != 5'd0) &&
                 ((bus.id_uses_rs1 && (ex_q.rd == bus.id_rs1)) ||
                  (bus.id_uses_rs2 && (ex_q.rd == bus.id_rs2)));
        bubble = hazard || bus.flush || !bus.id_valid;
    end

    always_comb begin
        ex_d    = '0;
        fwd_a_d = 2'b00;
        fwd_b_d = 2'b00;
        if (!bubble) begin
            ex_d    = '{valid: 1'b1, rd: bus.id_rd,
                        reg_write: bus.id_reg_write, mem_read: bus.id_mem_read};
            fwd_a_d = fwd_sel(bus.id_uses_rs1, bus.id_rs1, ex_q, mem_q);
            fwd_b_d = fwd_sel(bus.id_uses_rs2, bus.id_rs2, ex_q, mem_q);
        end
    end

    // STALL lasts one cycle: the bubble now in EX cannot create another load-use hazard.
    always_comb begin
        state_d = RUN;
        case (state_q)
            RUN:     state_d = hazard ? STALL : RUN;
            STALL:   state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            fwd_a_q <= 2'b00;
            fwd_b_q <= 2'b00;
            state_q <= RUN;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= ex_q;
            wb_q    <= mem_q;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
            state_q <= state_d;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (hazard && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= 16'h0000;
        else       cnt_q <= cnt_d;
    end

    assign bus.stall_count = cnt_q;
`else
    assign bus.stall_count = 16'h0000;
`endif

    assign bus.stall      = hazard;
    assign bus.forward_a  = fwd_a_q;
    assign bus.forward_b  = fwd_b_q;
    assign bus.fsm_state  = (state_q == STALL);
    assign bus.shadow_dbg = {ex_q, mem_q, wb_q};
endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed vector bench for hazard_forward_unit: one table row per ID cycle,
// plus a hand-written reset-during-load-use sequence.
module tb_hazard_forward_unit;
    logic clk = 1'b0;
    logic reset;

    hazard_forward_unit_if bus ();

    hazard_forward_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

`ifdef HAZARD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct {
        logic       rst;
        logic       vld;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       rw;
        logic       mr;
        logic       fl;
        logic       es;
        logic [1:0] efa;
        logic [1:0] efb;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   exp_cnt = 0;

    function automatic vec_t mk(input logic rst, input logic vld, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2, input logic rw,
                                input logic mr, input logic fl, input logic es,
                                input logic [1:0] efa, input logic [1:0] efb);
        vec_t v;
        v.rst = rst; v.vld = vld; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.u1 = u1; v.u2 = u2; v.rw = rw; v.mr = mr; v.fl = fl;
        v.es = es; v.efa = efa; v.efb = efb;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [15:0] act,
                       input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset            = v.rst;
        bus.id_valid     = v.vld;
        bus.id_rd        = v.rd;
        bus.id_rs1       = v.rs1;
        bus.id_rs2       = v.rs2;
        bus.id_uses_rs1  = v.u1;
        bus.id_uses_rs2  = v.u2;
        bus.id_reg_write = v.rw;
        bus.id_mem_read  = v.mr;
        bus.flush        = v.fl;
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        @(negedge clk);
        drive(v);
        #1;
        chk("stall", idx, {15'd0, bus.stall}, {15'd0, v.es});
        @(posedge clk);
        #1;
        n_vec++;
        if (v.rst) exp_cnt = 0;
        else if (v.es && exp_cnt != 16'hFFFF) exp_cnt++;
        chk("forward_a", idx, {14'd0, bus.forward_a}, {14'd0, v.efa});
        chk("forward_b", idx, {14'd0, bus.forward_b}, {14'd0, v.efb});
        chk("fsm_state", idx, {15'd0, bus.fsm_state}, {15'd0, (v.es && !v.rst)});
        chk("stall_count", idx, bus.stall_count, STATS ? exp_cnt[15:0] : 16'h0000);
    endtask

    initial begin
        //            rst vld rd  rs1 rs2 u1 u2 rw mr fl  es  fa     fb
        vecs.push_back(mk(1, 0, 0,  0,  0,  0, 0, 0, 0, 0, 0, 2'b00, 2'b00)); // 0 reset
        vecs.push_back(mk(0, 1, 5,  1,  2,  1, 1, 1, 0, 0, 0, 2'b00, 2'b00)); // 1 add x5,x1,x2
        vecs.push_back(mk(0, 1, 6,  5,  3,  1, 1, 1, 0, 0, 0, 2'b10, 2'b00)); // 2 add x6,x5,x3
        vecs.push_back(mk(0, 1, 7,  1,  2,  1, 1, 1, 0, 0, 0, 2'b00, 2'b00)); // 3 add x7
        vecs.push_back(mk(0, 1, 10, 11, 12, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00)); // 4 independent
        vecs.push_back(mk(0, 1, 9,  4,  7,  1, 1, 1, 0, 0, 0, 2'b00, 2'b01)); // 5 sub x9,x4,x7
        vecs.push_back(mk(0, 1, 8,  1,  0,  1, 0, 1, 1, 0, 0, 2'b00, 2'b00)); // 6 lw x8
        vecs.push_back(mk(0, 1, 9,  8,  8,  1, 1, 1, 0, 0, 1, 2'b00, 2'b00)); // 7 load-use stall
        vecs.push_back(mk(0, 1, 9,  8,  8,  1, 1, 1, 0, 0, 0, 2'b01, 2'b01)); // 8 replay
        vecs.push_back(mk(0, 1, 0,  1,  2,  1, 1, 1, 0, 0, 0, 2'b00, 2'b00)); // 9 add x0
        vecs.push_back(mk(0, 1, 1,  0,  0,  1, 1, 1, 0, 0, 0, 2'b00, 2'b00)); // 10 add x1,x0,x0
        vecs.push_back(mk(0, 1, 3,  1,  1,  1, 1, 1, 0, 0, 0, 2'b10, 2'b10)); // 11 add x3,x1,x1
        vecs.push_back(mk(0, 1, 3,  3,  0,  1, 1, 1, 0, 0, 0, 2'b10, 2'b00)); // 12 add x3 again
        vecs.push_back(mk(0, 1, 4,  3,  3,  1, 1, 1, 0, 0, 0, 2'b10, 2'b10)); // 13 nearest wins
        vecs.push_back(mk(0, 1, 5,  4,  3,  1, 0, 1, 0, 0, 0, 2'b10, 2'b00)); // 14 rs2 unused
        vecs.push_back(mk(0, 1, 8,  0,  0,  1, 0, 1, 1, 0, 0, 2'b00, 2'b00)); // 15 lw x8
        vecs.push_back(mk(0, 1, 9,  8,  1,  1, 1, 1, 0, 1, 0, 2'b00, 2'b00)); // 16 hazard+flush
        vecs.push_back(mk(0, 1, 9,  8,  1,  1, 1, 1, 0, 0, 0, 2'b01, 2'b00)); // 17 from MEM
        vecs.push_back(mk(0, 1, 2,  0,  0,  1, 0, 1, 1, 0, 0, 2'b00, 2'b00)); // 18 lw x2
        vecs.push_back(mk(1, 0, 0,  0,  0,  0, 0, 0, 0, 0, 0, 2'b00, 2'b00)); // 19 reset
        vecs.push_back(mk(1, 0, 0,  0,  0,  0, 0, 0, 0, 0, 0, 2'b00, 2'b00)); // 20 reset
        vecs.push_back(mk(0, 1, 3,  2,  9,  1, 1, 1, 0, 0, 0, 2'b00, 2'b00)); // 21 post-reset
        vecs.push_back(mk(0, 0, 5,  3,  3,  1, 1, 1, 0, 0, 0, 2'b00, 2'b00)); // 22 id invalid
        vecs.push_back(mk(0, 1, 4,  3,  3,  1, 1, 1, 0, 0, 0, 2'b01, 2'b01)); // 23 via bubble

        foreach (vecs[i]) apply_vec(vecs[i], i);

        // Reset arriving while a load-use hazard is in ID discards the load.
        apply_vec(mk(0, 1, 12, 0, 0, 1, 0, 1, 1, 0, 0, 2'b00, 2'b00), 100);
        @(negedge clk);
        drive(mk(1, 1, 13, 12, 0, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00));
        @(posedge clk);
        #1;
        n_vec++;
        exp_cnt = 0;
        chk("rst_fwd_a", 101, {14'd0, bus.forward_a}, 16'h0000);
        chk("rst_fsm", 101, {15'd0, bus.fsm_state}, 16'h0000);
        chk("rst_count", 101, bus.stall_count, 16'h0000);
        chk("rst_shadow", 101, bus.shadow_dbg[15:0], 16'h0000);
        apply_vec(mk(0, 1, 13, 12, 0, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00), 102);

        // Back-to-back load-use pairs: each stalls exactly once.
        apply_vec(mk(0, 1, 14, 0, 0, 1, 0, 1, 1, 0, 0, 2'b00, 2'b00), 103);
        apply_vec(mk(0, 1, 15, 0, 14, 0, 1, 1, 1, 0, 1, 2'b00, 2'b00), 104);
        apply_vec(mk(0, 1, 15, 0, 14, 0, 1, 1, 1, 0, 0, 2'b00, 2'b01), 105);
        apply_vec(mk(0, 1, 16, 15, 0, 1, 0, 1, 0, 0, 1, 2'b00, 2'b00), 106);
        apply_vec(mk(0, 1, 16, 15, 0, 1, 0, 1, 0, 0, 0, 2'b01, 2'b00), 107);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
